id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage_hazard_unit.sv | 30 +++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
//============================================================================
// Module      : mips_pkg
// Description : Shared MIPS pipeline definitions: architectural register
//               numbers, ALU operation width and encodings, and the control
//               bundle that travels from ID into EX.
// Revision    : 1.0 - initial release
//============================================================================
package mips_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd10;

    // Control fields registered into EX (reg_dst is consumed in ID when the
    // destination is resolved, so it is not carried forward).
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                jal;
        logic [ALU_OP_W-1:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
//============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between the decode side and the ID/EX register.
//               master : decoder/testbench - drives id_*, q1/q2, flush,
//                        ex_hold; observes ex_*, id_stall, stall_count.
//               slave  : id_ex_stage - the reverse.
// Revision    : 1.0 - initial release
//============================================================================
interface id_ex_stage_if;
    import mips_pkg::*;

    logic                id_valid;
    logic [31:0]         id_pc;
    logic [4:0]          id_rs;
    logic [4:0]          id_rt;
    logic [4:0]          id_rd;
    logic [31:0]         id_imm;
    logic [31:0]         q1;
    logic [31:0]         q2;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                id_alu_src;
    logic                id_reg_dst;
    logic                id_jal;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                flush;
    logic                ex_hold;

    logic                ex_valid;
    logic [31:0]         ex_pc;
    logic [31:0]         ex_a;
    logic [31:0]         ex_b;
    logic [31:0]         ex_imm;
    logic [4:0]          ex_rs;
    logic [4:0]          ex_rt;
    logic [4:0]          ex_dst;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;
    logic                ex_alu_src;
    logic                ex_jal;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                id_stall;
    logic [15:0]         stall_count;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, q1, q2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_jal, id_alu_op, flush, ex_hold,
        input  ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_jal, ex_alu_op, id_stall, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, q1, q2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_jal, id_alu_op, flush, ex_hold,
        output ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dst,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_jal, ex_alu_op, id_stall, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_unit.sv
`default_nettype none
//============================================================================
// Module      : hazard_unit
// Description : Combinational load-use detector. Flags when the instruction
//               in EX is a valid load whose (non-zero) destination is a
//               source of the valid instruction in ID.
//   ex_valid, ex_mem_read, ex_dst : instruction currently in EX
//   id_valid, id_rs, id_rt        : instruction currently in ID
//   load_use                      : hazard, ID must wait one cycle
// Revision    : 1.0 - initial release
//============================================================================
module hazard_unit
    import mips_pkg::*;
(
    input  wire logic       ex_valid,
    input  wire logic       ex_mem_read,
    input  wire logic [4:0] ex_dst,
    input  wire logic       id_valid,
    input  wire logic [4:0] id_rs,
    input  wire logic [4:0] id_rt,
    output logic            load_use
);

    // $zero never carries a real dependency, so it is excluded.
    assign load_use = ex_valid & ex_mem_read & id_valid &
                      (ex_dst != REG_ZERO) &
                      ((ex_dst == id_rs) | (ex_dst == id_rt));

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
//============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               branch flush, downstream hold and a saturating count of
//               load-use stall cycles.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low clear of all ex_* state and counter
//   bus   : id_ex_stage_if.slave - ID inputs, EX outputs, id_stall,
//           stall_count
// Revision    : 1.0 - initial release
//============================================================================
module id_ex_stage
    import mips_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset,
    id_ex_stage_if.slave bus
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_dst;
    idex_ctrl_t  r_ctrl;
    logic [15:0] r_stall_count;

    logic        w_load_use;
    logic [4:0]  w_dst;
    idex_ctrl_t  w_ctrl;

    hazard_unit u_hazard_unit (
        .ex_valid    (r_valid),
        .ex_mem_read (r_ctrl.mem_read),
        .ex_dst      (r_dst),
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .load_use    (w_load_use)
    );

    // Destination resolution: jal links into $ra, R-type uses rd, else rt.
    assign w_dst = bus.id_jal     ? REG_RA :
                   bus.id_reg_dst ? bus.id_rd : bus.id_rt;

    // Controls are killed for an invalid slot; a write to $zero is dropped
    // here so later stages never have to special-case it.
    always_comb begin
        w_ctrl = CTRL_NOP;
        if (bus.id_valid) begin
            w_ctrl.reg_write  = bus.id_reg_write & (w_dst != REG_ZERO);
            w_ctrl.mem_read   = bus.id_mem_read;
            w_ctrl.mem_write  = bus.id_mem_write;
            w_ctrl.mem_to_reg = bus.id_mem_to_reg;
            w_ctrl.alu_src    = bus.id_alu_src;
            w_ctrl.jal        = bus.id_jal;
            w_ctrl.alu_op     = bus.id_alu_op;
        end
    end

    // Priority: hold freezes, then flush/load-use insert a fully zeroed
    // bubble, otherwise load the decode slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dst   <= '0;
            r_ctrl  <= CTRL_NOP;
        end else if (bus.ex_hold) begin
            r_valid <= r_valid;
        end else if (bus.flush || w_load_use) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dst   <= '0;
            r_ctrl  <= CTRL_NOP;
        end else begin
            r_valid <= bus.id_valid;
            r_pc    <= bus.id_pc;
            r_a     <= bus.q1;
            r_b     <= bus.q2;
            r_imm   <= bus.id_imm;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_dst   <= w_dst;
            r_ctrl  <= w_ctrl;
        end
    end

    // Counts load-use cycles even when a flush coincides; frozen under hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (w_load_use && !bus.ex_hold && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_a          = r_a;
    assign bus.ex_b          = r_b;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_rs         = r_rs;
    assign bus.ex_rt         = r_rt;
    assign bus.ex_dst        = r_dst;
    assign bus.ex_reg_write  = r_ctrl.reg_write;
    assign bus.ex_mem_read   = r_ctrl.mem_read;
    assign bus.ex_mem_write  = r_ctrl.mem_write;
    assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.ex_alu_src    = r_ctrl.alu_src;
    assign bus.ex_jal        = r_ctrl.jal;
    assign bus.ex_alu_op     = r_ctrl.alu_op;
    assign bus.id_stall      = w_load_use | bus.ex_hold;
    assign bus.stall_count   = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
//============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    id_ex_stage_if bus_if ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_id();
        bus_if.id_valid      = 1'b0;
        bus_if.id_pc         = '0;
        bus_if.id_rs         = '0;
        bus_if.id_rt         = '0;
        bus_if.id_rd         = '0;
        bus_if.id_imm        = '0;
        bus_if.q1            = '0;
        bus_if.q2            = '0;
        bus_if.id_reg_write  = 1'b0;
        bus_if.id_mem_read   = 1'b0;
        bus_if.id_mem_write  = 1'b0;
        bus_if.id_mem_to_reg = 1'b0;
        bus_if.id_alu_src    = 1'b0;
        bus_if.id_reg_dst    = 1'b0;
        bus_if.id_jal        = 1'b0;
        bus_if.id_alu_op     = '0;
        bus_if.flush         = 1'b0;
        bus_if.ex_hold       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw $9, imm($2)
    task automatic drive_lw9(input logic [31:0] pc);
        clear_id();
        bus_if.id_valid      = 1'b1;
        bus_if.id_pc         = pc;
        bus_if.id_rs         = 5'd2;
        bus_if.id_rt         = 5'd9;
        bus_if.id_imm        = 32'd4;
        bus_if.id_mem_read   = 1'b1;
        bus_if.id_mem_to_reg = 1'b1;
        bus_if.id_reg_write  = 1'b1;
        bus_if.id_alu_src    = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_id();
        #2;
        check_val("rst_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("rst_ex_pc", bus_if.ex_pc, 32'd0);
        check_val("rst_stall_count", 32'(bus_if.stall_count), 32'd0);
        check_val("rst_id_stall", 32'(bus_if.id_stall), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Normal R/I instruction, destination rt
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h100;
        bus_if.id_rs        = 5'd3;
        bus_if.id_rt        = 5'd8;
        bus_if.id_rd        = 5'd12;
        bus_if.id_imm       = 32'hFFFF_FFF0;
        bus_if.q1           = 32'h11;
        bus_if.q2           = 32'h22;
        bus_if.id_reg_write = 1'b1;
        bus_if.id_alu_op    = 4'd2;
        #1;
        check_val("norm_id_stall", 32'(bus_if.id_stall), 32'd0);
        tick();
        check_val("norm_ex_valid", 32'(bus_if.ex_valid), 32'd1);
        check_val("norm_ex_dst", 32'(bus_if.ex_dst), 32'd8);
        check_val("norm_ex_a", bus_if.ex_a, 32'h11);
        check_val("norm_ex_b", bus_if.ex_b, 32'h22);
        check_val("norm_ex_reg_write", 32'(bus_if.ex_reg_write), 32'd1);
        check_val("norm_ex_pc", bus_if.ex_pc, 32'h100);
        check_val("norm_ex_imm", bus_if.ex_imm, 32'hFFFF_FFF0);
        check_val("norm_ex_alu_op", 32'(bus_if.ex_alu_op), 32'd2);
        check_val("norm_ex_rs", 32'(bus_if.ex_rs), 32'd3);

        // Load followed by dependent add -> one bubble
        drive_lw9(32'h104);
        tick();
        check_val("lw_ex_mem_read", 32'(bus_if.ex_mem_read), 32'd1);
        check_val("lw_ex_dst", 32'(bus_if.ex_dst), 32'd9);
        clear_id();
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h108;
        bus_if.id_rs        = 5'd9;
        bus_if.id_rt        = 5'd4;
        bus_if.id_rd        = 5'd10;
        bus_if.id_reg_dst   = 1'b1;
        bus_if.id_reg_write = 1'b1;
        bus_if.q1           = 32'h33;
        bus_if.q2           = 32'h44;
        #1;
        check_val("lu_id_stall", 32'(bus_if.id_stall), 32'd1);
        tick();
        check_val("lu_bubble_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("lu_bubble_dst", 32'(bus_if.ex_dst), 32'd0);
        check_val("lu_bubble_rw", 32'(bus_if.ex_reg_write), 32'd0);
        check_val("lu_stall_count", 32'(bus_if.stall_count), 32'd1);
        check_val("lu_stall_released", 32'(bus_if.id_stall), 32'd0);
        tick();
        check_val("lu_load_valid", 32'(bus_if.ex_valid), 32'd1);
        check_val("lu_load_dst", 32'(bus_if.ex_dst), 32'd10);
        check_val("lu_load_pc", bus_if.ex_pc, 32'h108);
        check_val("lu_load_a", bus_if.ex_a, 32'h33);
        check_val("lu_count_kept", 32'(bus_if.stall_count), 32'd1);

        // Load into $zero: write dropped, no hazard on $zero consumers
        clear_id();
        bus_if.id_valid      = 1'b1;
        bus_if.id_pc         = 32'h10C;
        bus_if.id_rs         = 5'd2;
        bus_if.id_mem_read   = 1'b1;
        bus_if.id_mem_to_reg = 1'b1;
        bus_if.id_reg_write  = 1'b1;
        tick();
        check_val("z_ex_mem_read", 32'(bus_if.ex_mem_read), 32'd1);
        check_val("z_ex_reg_write", 32'(bus_if.ex_reg_write), 32'd0);
        check_val("z_ex_dst", 32'(bus_if.ex_dst), 32'd0);
        clear_id();
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h110;
        bus_if.id_rd        = 5'd3;
        bus_if.id_reg_dst   = 1'b1;
        bus_if.id_reg_write = 1'b1;
        #1;
        check_val("z_id_stall", 32'(bus_if.id_stall), 32'd0);
        tick();
        check_val("z_ex_valid", 32'(bus_if.ex_valid), 32'd1);
        check_val("z_ex_dst2", 32'(bus_if.ex_dst), 32'd3);
        check_val("z_stall_count", 32'(bus_if.stall_count), 32'd1);

        // JAL: link to $ra, then same with flush -> bubble
        clear_id();
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h114;
        bus_if.id_jal       = 1'b1;
        bus_if.id_rd        = 5'd5;
        bus_if.id_reg_dst   = 1'b1;
        bus_if.id_reg_write = 1'b1;
        tick();
        check_val("jal_ex_dst", 32'(bus_if.ex_dst), 32'd31);
        check_val("jal_ex_jal", 32'(bus_if.ex_jal), 32'd1);
        check_val("jal_ex_rw", 32'(bus_if.ex_reg_write), 32'd1);
        bus_if.id_pc = 32'h118;
        bus_if.flush = 1'b1;
        tick();
        check_val("jalf_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("jalf_ex_jal", 32'(bus_if.ex_jal), 32'd0);
        check_val("jalf_ex_dst", 32'(bus_if.ex_dst), 32'd0);
        check_val("jalf_ex_pc", bus_if.ex_pc, 32'd0);

        // Hold dominates flush and load-use
        drive_lw9(32'h11C);
        tick();
        check_val("hf_lw_pc", bus_if.ex_pc, 32'h11C);
        clear_id();
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h120;
        bus_if.id_rs        = 5'd9;
        bus_if.id_reg_write = 1'b1;
        bus_if.flush        = 1'b1;
        bus_if.ex_hold      = 1'b1;
        #1;
        check_val("hf_id_stall", 32'(bus_if.id_stall), 32'd1);
        tick();
        check_val("hf_ex_valid", 32'(bus_if.ex_valid), 32'd1);
        check_val("hf_ex_pc", bus_if.ex_pc, 32'h11C);
        check_val("hf_ex_dst", 32'(bus_if.ex_dst), 32'd9);
        check_val("hf_ex_mem_read", 32'(bus_if.ex_mem_read), 32'd1);
        check_val("hf_stall_count", 32'(bus_if.stall_count), 32'd1);
        // Flush together with load-use: one bubble, stall still counted
        bus_if.ex_hold = 1'b0;
        #1;
        check_val("fl_id_stall", 32'(bus_if.id_stall), 32'd1);
        tick();
        check_val("fl_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("fl_ex_pc", bus_if.ex_pc, 32'd0);
        check_val("fl_stall_count", 32'(bus_if.stall_count), 32'd2);

        // Invalid decode slot: fields captured, controls gated
        clear_id();
        bus_if.id_pc        = 32'h124;
        bus_if.id_rt        = 5'd7;
        bus_if.id_reg_write = 1'b1;
        bus_if.id_mem_write = 1'b1;
        bus_if.id_mem_read  = 1'b1;
        bus_if.id_alu_op    = 4'd5;
        tick();
        check_val("inv_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("inv_ex_rw", 32'(bus_if.ex_reg_write), 32'd0);
        check_val("inv_ex_mw", 32'(bus_if.ex_mem_write), 32'd0);
        check_val("inv_ex_alu_op", 32'(bus_if.ex_alu_op), 32'd0);
        check_val("inv_ex_pc", bus_if.ex_pc, 32'h124);
        check_val("inv_ex_dst", 32'(bus_if.ex_dst), 32'd7);

        // Saturation of stall_count
        drive_lw9(32'h128);
        tick();
        clear_id();
        bus_if.id_valid = 1'b1;
        bus_if.id_pc    = 32'h12C;
        bus_if.id_rs    = 5'd9;
        force dut.r_stall_count = 16'hFFFF;
        #1;
        release dut.r_stall_count;
        #1;
        check_val("sat_preload", 32'(bus_if.stall_count), 32'h0000_FFFF);
        check_val("sat_id_stall", 32'(bus_if.id_stall), 32'd1);
        tick();
        check_val("sat_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("sat_stall_count", 32'(bus_if.stall_count), 32'h0000_FFFF);

        // Asynchronous reset in the middle of a load-use stall
        drive_lw9(32'h130);
        tick();
        clear_id();
        bus_if.id_valid = 1'b1;
        bus_if.id_pc    = 32'h134;
        bus_if.id_rs    = 5'd9;
        #1;
        check_val("ar_pre_stall", 32'(bus_if.id_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("ar_id_stall", 32'(bus_if.id_stall), 32'd0);
        check_val("ar_ex_valid", 32'(bus_if.ex_valid), 32'd0);
        check_val("ar_ex_pc", bus_if.ex_pc, 32'd0);
        check_val("ar_ex_mem_read", 32'(bus_if.ex_mem_read), 32'd0);
        check_val("ar_ex_dst", 32'(bus_if.ex_dst), 32'd0);
        check_val("ar_stall_count", 32'(bus_if.stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_id();
        bus_if.id_valid     = 1'b1;
        bus_if.id_pc        = 32'h200;
        bus_if.id_rt        = 5'd6;
        bus_if.q1           = 32'h55;
        bus_if.id_reg_write = 1'b1;
        tick();
        check_val("rel_ex_valid", 32'(bus_if.ex_valid), 32'd1);
        check_val("rel_ex_pc", bus_if.ex_pc, 32'h200);
        check_val("rel_ex_dst", 32'(bus_if.ex_dst), 32'd6);
        check_val("rel_ex_a", bus_if.ex_a, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
